// File: rtl/sobel_core_pipe.sv
// sobel_core_pipe -- pipelined 3x3 Sobel edge-magnitude core with valid/ready.
//
// Takes one 3x3 window per accepted beat and produces one edge pixel three
// register stages later. Stage 1 forms signed gradients gx/gy. Stage 2 forms the
// combined magnitude selected by the per-beat mode. Stage 3 clips the magnitude
// to the output width and flags saturation. All stages advance together on
// adv = ~valid_o | ready_i, so a stalled output freezes the whole pipe.
//
// Optional build macro: SOBEL_THRESHOLD_EN. It enables a loadable threshold
// register that binarises the clipped output.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   pix_i                 9 pixels, k = 3*row + col at [k*W +: W]
//   mode_i                00 |X|+|Y|, 01 max, 10 |X|, 11 |Y|
//   valid_i / ready_o     input handshake
//   pix_o, sat_o          edge magnitude and "was clipped" flag
//   valid_o / ready_i     output handshake
//   sat_clr_i, sat_cnt_o  saturation event counter (sticky at max)
//   thresh_i, thresh_ld_i threshold load (ignored unless SOBEL_THRESHOLD_EN)
module sobel_core_pipe #(
    parameter int PIXEL_WIDTH_IN  = 8,
    parameter int PIXEL_WIDTH_OUT = 8,
    parameter int SAT_CNT_WIDTH   = 16,
    parameter int THRESH_DEFAULT  = 128
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [9*PIXEL_WIDTH_IN-1:0]  pix_i,
    input  logic [1:0]                   mode_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    output logic [PIXEL_WIDTH_OUT-1:0]   pix_o,
    output logic                         sat_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    input  logic                         sat_clr_i,
    output logic [SAT_CNT_WIDTH-1:0]     sat_cnt_o,
    input  logic [PIXEL_WIDTH_OUT-1:0]   thresh_i,
    input  logic                         thresh_ld_i
);
    localparam int W  = PIXEL_WIDTH_IN;
    localparam int O  = PIXEL_WIDTH_OUT;
    localparam int GW = W + 3;   // signed gradient width, holds +/-4(2^W-1)
    localparam int AW = W + 2;   // absolute gradient width
    localparam int MW = W + 3;   // combined magnitude width (ax+ay)
    localparam logic [MW-1:0] MAX_M = MW'((64'd1 << O) - 64'd1);

    // Pipeline state
    logic                 v1_q, v2_q, v3_q;
    logic signed [GW-1:0] gx_q, gy_q;
    logic [1:0]           mode_q;
    logic [MW-1:0]        m_q;
    logic [O-1:0]         pix_q;
    logic                 sat_q;
    logic [SAT_CNT_WIDTH-1:0] sat_cnt_q;

    logic adv;
    assign adv     = ~v3_q | ready_i;
    assign ready_o = adv;

    // Zero-extended signed copies of the nine pixels
    logic signed [GW-1:0] p [9];
    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_unpack
            assign p[gi] = $signed({3'b000, pix_i[gi*W +: W]});
        end
    endgenerate

    // Stage 1 combinational: gradients. The shift doubles without widening.
    logic signed [GW-1:0] gx_d, gy_d;
    assign gx_d = (p[2] - p[0]) + ((p[5] - p[3]) <<< 1) + (p[8] - p[6]);
    assign gy_d = (p[6] - p[0]) + ((p[7] - p[1]) <<< 1) + (p[8] - p[2]);

    // Stage 2 combinational: absolute values and mode combine
    logic [GW-1:0] ngx, ngy;
    logic [AW-1:0] ax, ay;
    logic [MW-1:0] m_d;
    assign ngx = -gx_q;
    assign ngy = -gy_q;
    assign ax  = gx_q[GW-1] ? ngx[AW-1:0] : gx_q[AW-1:0];
    assign ay  = gy_q[GW-1] ? ngy[AW-1:0] : gy_q[AW-1:0];

    always_comb begin
        m_d = '0;
        case (mode_q)
            2'b00:   m_d = {1'b0, ax} + {1'b0, ay};
            2'b01:   m_d = (ax >= ay) ? {1'b0, ax} : {1'b0, ay};
            2'b10:   m_d = {1'b0, ax};
            default: m_d = {1'b0, ay};
        endcase
    end

    // Stage 3 combinational: clip, and optional binarisation
    logic         sat_d;
    logic [O-1:0] clip_val;
    logic [O-1:0] pix_d;
    assign sat_d    = (m_q > MAX_M);
    assign clip_val = sat_d ? {O{1'b1}} : m_q[O-1:0];

`ifdef SOBEL_THRESHOLD_EN
    logic [O-1:0] thr_q;
    always_ff @(posedge clk_i) begin
        if (rst_i)
            thr_q <= O'(THRESH_DEFAULT);
        else if (thresh_ld_i)
            thr_q <= thresh_i;
    end
    assign pix_d = (clip_val >= thr_q) ? {O{1'b1}} : {O{1'b0}};
`else
    logic unused_thresh;
    assign unused_thresh = ^{thresh_i, thresh_ld_i};
    assign pix_d = clip_val;
`endif

    // Pipeline registers: every stage moves only when the output can move
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            gx_q   <= '0;
            gy_q   <= '0;
            mode_q <= 2'b00;
            m_q    <= '0;
            pix_q  <= '0;
            sat_q  <= 1'b0;
        end else if (adv) begin
            v1_q   <= valid_i;
            gx_q   <= gx_d;
            gy_q   <= gy_d;
            mode_q <= mode_i;
            v2_q   <= v1_q;
            m_q    <= m_d;
            v3_q   <= v2_q;
            pix_q  <= pix_d;
            sat_q  <= sat_d;
        end
    end

    // Saturation counter: clear wins, otherwise sticky increment on delivery
    always_ff @(posedge clk_i) begin
        if (rst_i)
            sat_cnt_q <= '0;
        else if (sat_clr_i)
            sat_cnt_q <= '0;
        else if (v3_q && ready_i && sat_q && !(&sat_cnt_q))
            sat_cnt_q <= sat_cnt_q + 1'b1;
    end

    assign valid_o   = v3_q;
    assign pix_o     = pix_q;
    assign sat_o     = sat_q;
    assign sat_cnt_o = sat_cnt_q;

endmodule

// File: tb/tb_sobel_core_pipe.sv
module tb_sobel_core_pipe;
    localparam int W   = 8;
    localparam int O   = 8;
    localparam int SCW = 2;
    localparam logic [31:0] RDY_PAT = 32'hB53C96E7;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic [9*W-1:0] pix_i;
    logic [1:0]     mode_i;
    logic           valid_i;
    logic           ready_o;
    logic [O-1:0]   pix_o;
    logic           sat_o;
    logic           valid_o;
    logic           ready_i;
    logic           sat_clr_i;
    logic [SCW-1:0] sat_cnt_o;
    logic [O-1:0]   thresh_i;
    logic           thresh_ld_i;

    int tests_run    = 0;
    int tests_failed = 0;
    int thr_model    = 128;

    logic [9*W-1:0] win_a, win_flip, win_sat;

    always #5 clk_i = ~clk_i;

    sobel_core_pipe #(
        .PIXEL_WIDTH_IN (W),
        .PIXEL_WIDTH_OUT(O),
        .SAT_CNT_WIDTH  (SCW),
        .THRESH_DEFAULT (128)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .pix_i      (pix_i),
        .mode_i     (mode_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .pix_o      (pix_o),
        .sat_o      (sat_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .sat_clr_i  (sat_clr_i),
        .sat_cnt_o  (sat_cnt_o),
        .thresh_i   (thresh_i),
        .thresh_ld_i(thresh_ld_i)
    );

    // Pack a window given in raster order p0..p8
    function automatic logic [9*W-1:0] win9(input int p0, input int p1, input int p2,
                                            input int p3, input int p4, input int p5,
                                            input int p6, input int p7, input int p8);
        return {8'(p8), 8'(p7), 8'(p6), 8'(p5), 8'(p4), 8'(p3), 8'(p2), 8'(p1), 8'(p0)};
    endfunction

    // Output pixel expected for a hand-computed magnitude m
    function automatic logic [O-1:0] exp_pix(input int m);
        int c;
        c = (m > 255) ? 255 : m;
`ifdef SOBEL_THRESHOLD_EN
        return (c >= thr_model) ? 8'd255 : 8'd0;
`else
        return 8'(c);
`endif
    endfunction

    task automatic test_reset();
        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1; sat_clr_i = 1'b0;
        thresh_i = '0; thresh_ld_i = 1'b0; pix_i = '0; mode_i = 2'b00;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        tests_run++;
        if (valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_valid_o: got %b want 0", valid_o); end
        tests_run++;
        if (pix_o !== 8'd0) begin tests_failed++; $display("FAIL reset_pix_o: got %0d want 0", pix_o); end
        tests_run++;
        if (sat_o !== 1'b0) begin tests_failed++; $display("FAIL reset_sat_o: got %b want 0", sat_o); end
        tests_run++;
        if (sat_cnt_o !== 2'd0) begin tests_failed++; $display("FAIL reset_sat_cnt: got %0d want 0", sat_cnt_o); end
        tests_run++;
        if (ready_o !== 1'b1) begin tests_failed++; $display("FAIL reset_ready_o: got %b want 1", ready_o); end
        $display("[TB] reset done");
        @(negedge clk_i);
    endtask

    // Four beats of the same window, one per mode: magnitudes 16/12/4/12
    task automatic test_modes();
        int exp_m [4] = '{16, 12, 4, 12};
        int first_v = -1;
        int got = 0;
        ready_i = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (valid_o === 1'b1) begin
                if (first_v < 0) first_v = cyc;
                tests_run++;
                if (got >= 4) begin
                    tests_failed++; $display("FAIL modes_extra: got extra beat pix=%0d want none", pix_o);
                end else if (pix_o !== exp_pix(exp_m[got]) || sat_o !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL modes_beat%0d: got pix=%0d sat=%b want pix=%0d sat=0",
                             got, pix_o, sat_o, exp_pix(exp_m[got]));
                end
                $display("[TB] modes beat %0d pix=%0d sat=%b", got, pix_o, sat_o);
                got++;
            end
            if (cyc < 4) begin valid_i = 1'b1; pix_i = win_a; mode_i = 2'(cyc); end
            else valid_i = 1'b0;
            @(negedge clk_i);
        end
        tests_run++;
        if (first_v != 3) begin tests_failed++; $display("FAIL modes_latency: got %0d want 3", first_v); end
        tests_run++;
        if (got != 4) begin tests_failed++; $display("FAIL modes_count: got %0d want 4", got); end
    endtask

    // Vertically flipped window: gy = -12, gx = 4
    task automatic test_abs();
        bit seen = 0;
        ready_i = 1'b1;
        valid_i = 1'b1; pix_i = win_flip; mode_i = 2'b00;
        @(negedge clk_i);
        valid_i = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (valid_o === 1'b1) seen = 1;
            else @(negedge clk_i);
        end
        tests_run++;
        if (!seen) begin
            tests_failed++; $display("FAIL abs_timeout: got no valid_o want one beat");
        end else if (pix_o !== exp_pix(16) || sat_o !== 1'b0) begin
            tests_failed++; $display("FAIL abs_pix: got pix=%0d sat=%b want pix=%0d sat=0", pix_o, sat_o, exp_pix(16));
        end
        $display("[TB] abs beat pix=%0d sat=%b", pix_o, sat_o);
        @(negedge clk_i);
    endtask

    // Saturating beat held under backpressure; counter moves only on delivery
    task automatic test_saturation();
        bit seen = 0;
        logic [O-1:0] held;
        ready_i = 1'b0;
        valid_i = 1'b1; pix_i = win_sat; mode_i = 2'b00;
        @(negedge clk_i);
        valid_i = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (valid_o === 1'b1) seen = 1;
            else @(negedge clk_i);
        end
        tests_run++;
        if (!seen || pix_o !== exp_pix(1020) || sat_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL sat_beat: got valid=%b pix=%0d sat=%b want valid=1 pix=%0d sat=1",
                     valid_o, pix_o, sat_o, exp_pix(1020));
        end
        tests_run++;
        if (sat_cnt_o !== 2'd0) begin tests_failed++; $display("FAIL sat_cnt_stalled: got %0d want 0", sat_cnt_o); end
        held = pix_o;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            tests_run++;
            if (valid_o !== 1'b1 || pix_o !== held || sat_o !== 1'b1 || sat_cnt_o !== 2'd0) begin
                tests_failed++;
                $display("FAIL sat_hold%0d: got valid=%b pix=%0d sat=%b cnt=%0d want 1/%0d/1/0",
                         i, valid_o, pix_o, sat_o, sat_cnt_o, held);
            end
        end
        ready_i = 1'b1;
        @(negedge clk_i);
        tests_run++;
        if (sat_cnt_o !== 2'd1 || valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL sat_delivered: got cnt=%0d valid=%b want cnt=1 valid=0", sat_cnt_o, valid_o);
        end
        $display("[TB] saturated beat delivered cnt=%0d", sat_cnt_o);
    endtask

    // Ten beats, per-beat modes, pseudo-random backpressure
    task automatic test_back_to_back();
        logic [O-1:0] exp_q [$];
        logic [O-1:0] exp_v;
        logic [O-1:0] held_pix = '0;
        bit held = 0;
        int sent = 0;
        int delivered = 0;
        int k;
        for (int cyc = 0; cyc < 200 && delivered < 10; cyc++) begin
            if (held) begin
                tests_run++;
                if (valid_o !== 1'b1 || pix_o !== held_pix) begin
                    tests_failed++;
                    $display("FAIL b2b_stable: got valid=%b pix=%0d want 1/%0d", valid_o, pix_o, held_pix);
                end
            end
            ready_i = RDY_PAT[cyc % 32];
            k = 3 * sent + 1;
            if (sent < 10) begin
                valid_i = 1'b1; pix_i = win9(0, 0, k, 0, 0, 0, 0, 0, k); mode_i = 2'(sent % 4);
            end else valid_i = 1'b0;
            #1;
            if (valid_i && ready_o) begin
                // gx = 2k, gy = 0: modes 00/01/10 give 2k, mode 11 gives 0
                exp_q.push_back(exp_pix((sent % 4 == 3) ? 0 : 2 * k));
                sent++;
            end
            held = 0;
            if (valid_o === 1'b1) begin
                if (ready_i) begin
                    tests_run++;
                    if (exp_q.size() == 0) begin
                        tests_failed++; $display("FAIL b2b_unexpected: got pix=%0d want no beat", pix_o);
                    end else begin
                        exp_v = exp_q.pop_front();
                        if (pix_o !== exp_v || sat_o !== 1'b0) begin
                            tests_failed++;
                            $display("FAIL b2b_beat%0d: got pix=%0d sat=%b want pix=%0d sat=0",
                                     delivered, pix_o, sat_o, exp_v);
                        end
                    end
                    $display("[TB] b2b beat %0d pix=%0d", delivered, pix_o);
                    delivered++;
                end else begin
                    held = 1; held_pix = pix_o;
                end
            end
            @(negedge clk_i);
        end
        valid_i = 1'b0; ready_i = 1'b1;
        tests_run++;
        if (delivered != 10 || sent != 10) begin
            tests_failed++; $display("FAIL b2b_count: got sent=%0d delivered=%0d want 10/10", sent, delivered);
        end
        repeat (4) @(negedge clk_i);
        tests_run++;
        if (valid_o !== 1'b0) begin tests_failed++; $display("FAIL b2b_drain: got valid=%b want 0", valid_o); end
    endtask

    // Counter starts at 1; three more saturated beats must stick at 3
    task automatic test_sat_limit();
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            valid_i = 1'b1; pix_i = win_sat; mode_i = 2'b00;
            @(negedge clk_i);
        end
        valid_i = 1'b0;
        repeat (5) @(negedge clk_i);
        tests_run++;
        if (sat_cnt_o !== 2'd3) begin tests_failed++; $display("FAIL sat_sticky: got %0d want 3", sat_cnt_o); end
        $display("[TB] sat counter after limit cnt=%0d", sat_cnt_o);
    endtask

    // Clear coinciding with a saturated delivery gives 0
    task automatic test_sat_clear();
        bit seen = 0;
        ready_i = 1'b0;
        valid_i = 1'b1; pix_i = win_sat; mode_i = 2'b00;
        @(negedge clk_i);
        valid_i = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (valid_o === 1'b1) seen = 1;
            else @(negedge clk_i);
        end
        tests_run++;
        if (!seen || sat_o !== 1'b1) begin
            tests_failed++; $display("FAIL clr_setup: got valid=%b sat=%b want 1/1", valid_o, sat_o);
        end
        ready_i = 1'b1; sat_clr_i = 1'b1;
        @(negedge clk_i);
        sat_clr_i = 1'b0;
        tests_run++;
        if (sat_cnt_o !== 2'd0 || valid_o !== 1'b0) begin
            tests_failed++; $display("FAIL clr_priority: got cnt=%0d valid=%b want 0/0", sat_cnt_o, valid_o);
        end
        $display("[TB] clear with delivery cnt=%0d", sat_cnt_o);
    endtask

    // Reset with two beats in flight discards them
    task automatic test_reset_midstream();
        ready_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            valid_i = 1'b1; pix_i = win_sat; mode_i = 2'b00;
            @(negedge clk_i);
        end
        valid_i = 1'b0; rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        tests_run++;
        if (valid_o !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_valid: got %b want 0", valid_o); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            tests_run++;
            if (valid_o !== 1'b0 || sat_cnt_o !== 2'd0) begin
                tests_failed++;
                $display("FAIL rst_mid_stale%0d: got valid=%b cnt=%0d want 0/0", i, valid_o, sat_cnt_o);
            end
        end
        thr_model = 128;
        $display("[TB] reset mid-stream done");
    endtask

    // Threshold load 16: binarised with the feature, ignored without it
    task automatic test_threshold();
        int exp_m [2] = '{16, 4};
        int got = 0;
        ready_i = 1'b1;
        thresh_i = 8'd16; thresh_ld_i = 1'b1;
        @(negedge clk_i);
        thresh_ld_i = 1'b0;
`ifdef SOBEL_THRESHOLD_EN
        thr_model = 16;
`endif
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (valid_o === 1'b1) begin
                tests_run++;
                if (got >= 2) begin
                    tests_failed++; $display("FAIL thr_extra: got pix=%0d want none", pix_o);
                end else if (pix_o !== exp_pix(exp_m[got])) begin
                    tests_failed++;
                    $display("FAIL thr_beat%0d: got pix=%0d want %0d", got, pix_o, exp_pix(exp_m[got]));
                end
                $display("[TB] threshold beat %0d pix=%0d", got, pix_o);
                got++;
            end
            if (cyc < 2) begin valid_i = 1'b1; pix_i = win_a; mode_i = (cyc == 0) ? 2'b00 : 2'b10; end
            else valid_i = 1'b0;
            @(negedge clk_i);
        end
        tests_run++;
        if (got != 2) begin tests_failed++; $display("FAIL thr_count: got %0d want 2", got); end
    endtask

    initial begin
        win_a    = win9(0, 0, 2,   0, 0, 0,   2, 4, 4);
        win_flip = win9(2, 4, 4,   0, 0, 0,   0, 0, 2);
        win_sat  = win9(0, 0, 255, 0, 0, 255, 0, 0, 255);
        test_reset();
        test_modes();
        test_abs();
        test_saturation();
        test_back_to_back();
        test_sat_limit();
        test_sat_clear();
        test_reset_midstream();
        test_threshold();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
